// File: rtl/vend_pkg.sv
// Shared key codes, coin values, FSM encodings and price lookup for the vending controller.
package vend_pkg;

    localparam int CW = 8;

    localparam logic [2:0] KEY_NONE    = 3'd0;
    localparam logic [2:0] KEY_CANCEL  = 3'd6;
    localparam logic [2:0] KEY_CONFIRM = 3'd7;

    localparam logic [1:0] COIN_1  = 2'b00;
    localparam logic [1:0] COIN_2  = 2'b01;
    localparam logic [1:0] COIN_5  = 2'b10;
    localparam logic [1:0] COIN_20 = 2'b11;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SELECTED = 2'd1;
    localparam logic [1:0] ST_VEND     = 2'd2;
    localparam logic [1:0] ST_REFUND   = 2'd3;

    typedef logic [5:1][CW-1:0] price_tab_t;

    function automatic logic [CW-1:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_1:  return CW'(1);
            COIN_2:  return CW'(2);
            COIN_5:  return CW'(5);
            default: return CW'(20);
        endcase
    endfunction

    // Selection 0 (none) prices at zero; it never reaches VEND.
    function automatic logic [CW-1:0] price_of(input logic [2:0] s, input price_tab_t tab);
        case (s)
            3'd1:    return tab[1];
            3'd2:    return tab[2];
            3'd3:    return tab[3];
            3'd4:    return tab[4];
            3'd5:    return tab[5];
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/vend_controller_key_event_detect.sv
// Registers the previous key code and flags a key event on a none-to-key transition.
module key_event_detect
    import vend_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] kp_out,
    output logic       key_evt,
    output logic [2:0] key_code
);

    logic [2:0] kp_prev;

    always_ff @(posedge clk) begin
        if (!reset) kp_prev <= KEY_NONE;
        else        kp_prev <= kp_out;
    end

    assign key_evt  = (kp_prev == KEY_NONE) && (kp_out != KEY_NONE);
    assign key_code = kp_out;

endmodule

// File: rtl/vend_controller.sv
// One-purchase-at-a-time vending FSM: coins build credit, select/confirm vends, change is paid out.
module vend_controller
    import vend_pkg::*;
#(
    parameter logic [CW-1:0] CREDIT_MAX = 8'd40,
    parameter logic [CW-1:0] PRICE_1    = 8'd5,
    parameter logic [CW-1:0] PRICE_2    = 8'd10,
    parameter logic [CW-1:0] PRICE_3    = 8'd15,
    parameter logic [CW-1:0] PRICE_4    = 8'd20,
    parameter logic [CW-1:0] PRICE_5    = 8'd25
)(
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    kp_out,
    input  logic          coin_valid,
    input  logic [1:0]    coin_code,
    output logic [CW-1:0] credit,
    output logic [2:0]    sel,
    output logic          dispense,
    output logic [2:0]    dispense_sel,
    output logic          change_valid,
    output logic [CW-1:0] change_amt,
    output logic          coin_reject,
    output logic          insufficient
);

    localparam price_tab_t PRICES = {PRICE_5, PRICE_4, PRICE_3, PRICE_2, PRICE_1};

    logic [1:0]    state;
    logic          key_evt;
    logic [2:0]    key_code;
    logic [CW:0]   coin_sum;
    logic          coin_ok;
    logic [CW-1:0] credit_in;
    logic [CW-1:0] sel_price;
    logic [CW-1:0] remain;

    key_event_detect u_key (
        .clk      (clk),
        .reset    (reset),
        .kp_out   (kp_out),
        .key_evt  (key_evt),
        .key_code (key_code)
    );

    // Extra bit on the sum keeps a near-ceiling credit from wrapping past the limit check.
    assign coin_sum  = {1'b0, credit} + {1'b0, coin_value(coin_code)};
    assign coin_ok   = coin_valid && (state == ST_IDLE || state == ST_SELECTED)
                       && (coin_sum <= {1'b0, CREDIT_MAX});
    assign credit_in = coin_ok ? coin_sum[CW-1:0] : credit;
    assign sel_price = price_of(sel, PRICES);
    assign remain    = credit - sel_price;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            credit       <= '0;
            sel          <= '0;
            dispense     <= 1'b0;
            dispense_sel <= '0;
            change_valid <= 1'b0;
            change_amt   <= '0;
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
        end else begin
            dispense     <= 1'b0;
            dispense_sel <= '0;
            change_valid <= 1'b0;
            change_amt   <= '0;
            insufficient <= 1'b0;
            coin_reject  <= coin_valid && !coin_ok;
            case (state)
                ST_IDLE, ST_SELECTED: begin
                    credit <= credit_in;
                    if (key_evt) begin
                        if (key_code == KEY_CANCEL) begin
                            sel   <= '0;
                            state <= (credit_in != '0) ? ST_REFUND : ST_IDLE;
                        end else if (key_code == KEY_CONFIRM) begin
                            // Price check sees the registered credit, not a coin landing this edge.
                            if (state == ST_SELECTED) begin
                                if (credit >= sel_price) state <= ST_VEND;
                                else                     insufficient <= 1'b1;
                            end
                        end else begin
                            sel   <= key_code;
                            state <= ST_SELECTED;
                        end
                    end
                end
                ST_VEND: begin
                    dispense     <= 1'b1;
                    dispense_sel <= sel;
                    credit       <= remain;
                    sel          <= '0;
                    state        <= (remain != '0) ? ST_REFUND : ST_IDLE;
                end
                ST_REFUND: begin
                    change_valid <= 1'b1;
                    change_amt   <= credit;
                    credit       <= '0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Directed purchase scenarios plus random traffic, checked against a transaction-level vending model.
module tb_vend_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] kp_out;
    logic       coin_valid;
    logic [1:0] coin_code;
    logic [7:0] credit;
    logic [2:0] sel;
    logic       dispense;
    logic [2:0] dispense_sel;
    logic       change_valid;
    logic [7:0] change_amt;
    logic       coin_reject;
    logic       insufficient;

    vend_controller dut (
        .clk          (clk),
        .reset        (reset),
        .kp_out       (kp_out),
        .coin_valid   (coin_valid),
        .coin_code    (coin_code),
        .credit       (credit),
        .sel          (sel),
        .dispense     (dispense),
        .dispense_sel (dispense_sel),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .coin_reject  (coin_reject),
        .insufficient (insufficient)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int price_tab [6] = '{0, 5, 10, 15, 20, 25};
    int coin_tab  [4] = '{1, 2, 5, 20};

    // Model: a nonzero selection means "item chosen"; vending and refunding are pending actions.
    int m_credit, m_sel, m_prev;
    bit m_vend_due, m_refund_due;
    int e_disp, e_dsel, e_chg, e_amt, e_rej, e_insuf;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task model(input bit r, input int k, input bit cv, input int cc);
        bit evt, accept;
        int pre, post;
        e_disp = 0; e_dsel = 0; e_chg = 0; e_amt = 0; e_rej = 0; e_insuf = 0;
        if (!r) begin
            m_credit = 0; m_sel = 0; m_prev = 0; m_vend_due = 0; m_refund_due = 0;
            return;
        end
        evt    = (m_prev == 0) && (k != 0);
        m_prev = k;
        accept = cv && !m_vend_due && !m_refund_due && (m_credit + coin_tab[cc] <= 40);
        e_rej  = (cv && !accept) ? 1 : 0;
        pre    = m_credit;
        post   = accept ? m_credit + coin_tab[cc] : m_credit;
        if (m_vend_due) begin
            e_disp = 1; e_dsel = m_sel;
            m_credit = m_credit - price_tab[m_sel];
            m_sel = 0; m_vend_due = 0;
            m_refund_due = (m_credit > 0);
        end else if (m_refund_due) begin
            e_chg = 1; e_amt = m_credit;
            m_credit = 0; m_refund_due = 0;
        end else begin
            m_credit = post;
            if (evt) begin
                if (k == 6) begin
                    m_sel = 0;
                    m_refund_due = (post > 0);
                end else if (k == 7) begin
                    if (m_sel != 0) begin
                        if (pre >= price_tab[m_sel]) m_vend_due = 1;
                        else                         e_insuf = 1;
                    end
                end else begin
                    m_sel = k;
                end
            end
        end
    endtask

    task automatic step(input bit r, input int k, input bit cv, input int cc);
        reset = r; kp_out = 3'(k); coin_valid = cv; coin_code = 2'(cc);
        @(posedge clk);
        model(r, k, cv, cc);
        #1;
        chk("credit",       int'(credit),       m_credit);
        chk("sel",          int'(sel),          m_sel);
        chk("dispense",     int'(dispense),     e_disp);
        chk("dispense_sel", int'(dispense_sel), e_dsel);
        chk("change_valid", int'(change_valid), e_chg);
        chk("change_amt",   int'(change_amt),   e_amt);
        chk("coin_reject",  int'(coin_reject),  e_rej);
        chk("insufficient", int'(insufficient), e_insuf);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0);
    endtask

    task automatic coin(input int cc);
        step(1, 0, 1, cc);
    endtask

    task automatic key(input int k);
        step(1, k, 0, 0);
        step(1, 0, 0, 0);
    endtask

    initial begin
        int k;
        reset = 1'b0; kp_out = '0; coin_valid = 1'b0; coin_code = '0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("reset_credit", int'(credit), 0);

        // 1: 20+5 credit, buy selection 5 exactly
        coin(3); coin(2);
        chk("t1_credit", int'(credit), 25);
        key(5); key(7);
        idle(3);

        // 2: 20 credit, buy selection 3, change of 5
        coin(3); key(3); key(7);
        idle(3);

        // 3: insufficient then cancel refunds 2
        coin(1); key(4); key(7);
        chk("t3_sel_kept", int'(sel), 4);
        key(6); idle(2);

        // 4: credit ceiling
        coin(3); coin(2); coin(2); coin(2); coin(1); coin(0);
        coin(1);
        chk("t4_at_max", int'(credit), 40);
        coin(0);
        key(6); idle(2);

        // 5: held key fires once; direct key change gives no event
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
        step(1, 2, 0, 0);
        step(1, 0, 0, 0);
        chk("t5_sel", int'(sel), 1);
        key(6); idle(1);

        // 6: reset on the vend cycle loses credit; coin during refund rejected
        coin(3); key(4);
        step(1, 7, 0, 0);
        step(0, 0, 0, 0);
        idle(2);
        coin(2); step(1, 6, 0, 0);
        step(1, 0, 1, 1);
        idle(2);

        // Confirm coinciding with a coin uses the pre-coin credit
        coin(2); key(2); step(1, 7, 1, 2); idle(4);

        // Random traffic: keys held for random lengths, sporadic coins and resets
        k = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0)
                k = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 7));
            step(($urandom_range(0, 299) != 0), k,
                 ($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Sits directly downstream of the keypad mapper and consumes its 3-bit key code `kp_out`.
- Combines key events with coin-acceptor pulses to run one purchase at a time: select, confirm, dispense, return change.
- Outputs drive the dispenser motor sequencer and the change hopper.

Parameters:
- CW, 8, credit/price/change width in bits (unit = 5 cents)
- CREDIT_MAX, 8'd40, credit ceiling (200 cents)
- PRICE_1, 8'd5, price of selection 1
- PRICE_2, 8'd10, price of selection 2
- PRICE_3, 8'd15, price of selection 3
- PRICE_4, 8'd20, price of selection 4
- PRICE_5, 8'd25, price of selection 5

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- kp_out  in  3  key code: 0=none, 1..5=select, 6=cancel, 7=confirm; held while key is down
- coin_valid  in  1  one-cycle coin strobe
- coin_code  in  2  00=1 unit, 01=2, 10=5, 11=20
- credit  out  CW  current accumulated credit
- sel  out  3  latched selection, 0 = none
- dispense  out  1  one-cycle pulse: vend `dispense_sel`
- dispense_sel  out  3  selection being vended, valid with `dispense`
- change_valid  out  1  one-cycle pulse: pay out `change_amt`
- change_amt  out  CW  change units, valid with `change_valid`
- coin_reject  out  1  one-cycle pulse: return the coin just inserted
- insufficient  out  1  one-cycle pulse: confirm with too little credit

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE, credit=0, sel=0, kp_prev=0. All pulses and `dispense_sel`/`change_amt` are 0. Reset wins over every other event, including mid-VEND; the credit is lost by design.
- Key event: `kp_prev` registers `kp_out` every cycle. An event fires when kp_prev==0 and kp_out!=0. A held key gives exactly one event. A direct nonzero-to-nonzero change gives no event.
- Coin: `coin_valid` is accepted only in IDLE or SELECTED, and only if credit+value <= CREDIT_MAX. The sum is computed at CW+1 bits, so there is no wrap. An accepted coin updates credit at the same edge. Any other coin raises `coin_reject` at the next cycle.
- All outputs are registered. Each pulse is high for exactly one cycle.

State machine:
- IDLE:
  - select k: sel=k, go to SELECTED.
  - cancel: if credit>0 go to REFUND, else stay.
  - confirm: ignored.
- SELECTED:
  - select k: replaces sel.
  - cancel: sel=0, then REFUND if credit>0, else IDLE.
  - confirm with credit >= PRICE_sel: go to VEND.
  - confirm with credit < PRICE_sel: `insufficient` pulses next cycle, stay in SELECTED.
- VEND (1 cycle):
  - dispense=1, dispense_sel=sel, credit -= PRICE_sel, sel=0.
  - Then REFUND if the remainder > 0, else IDLE.
- REFUND (1 cycle):
  - change_valid=1, change_amt=credit, credit=0, then IDLE.
- Simultaneous coin and confirm in SELECTED: the price comparison uses the pre-coin (registered) credit. The coin is still added that edge. In the VEND transition, the deduction applies to credit + coin.
- Key events arriving in VEND/REFUND are dropped. kp_prev still updates, so a key held across the state change does not re-fire.
- Latency:
  - confirm event at edge N: state=VEND after edge N, `dispense` high in cycle N+1, `change_valid` high in cycle N+2.
  - cancel event at edge N: `change_valid` high in cycle N+1.

Decomposition:
- Shared package vend_pkg holds:
  - key-code constants KEY_NONE, KEY_CANCEL=6, KEY_CONFIRM=7
  - coin-code values
  - state encodings IDLE/SELECTED/VEND/REFUND
  - price-lookup function indexed by sel
- One sub-module is natural: key_event_detect (kp_prev register plus edge detect, emits `key_evt` and `key_code`). Everything else stays in vend_controller.

Test Plan:
1. Reset then coins 11,10 (20+5=25): credit=25. Select 5 (kp_out 0→5→0), confirm → `dispense` one pulse, dispense_sel=5. credit=0. No `change_valid`.
2. credit=20 (one 11 coin), select 3, confirm → dispense_sel=3, then `change_valid` with change_amt=5. Final credit=0, state IDLE.
3. credit=2, select 4, confirm → `insufficient` one pulse, credit stays 2, sel=4. Cancel → change_amt=2, sel=0.
4. credit=38, coin 01 accepted (credit=40). Coin 00 → coin_reject=1, credit stays 40.
5. Hold kp_out=1 for 10 cycles → sel=1, exactly one event. kp_out 1→2 direct → sel remains 1.
6. Confirm (credit=20, PRICE_4) asserted, then reset=0 on the VEND cycle → next cycle all outputs 0, credit=0. Coin during REFUND → coin_reject pulse.
